// File: rtl/mod_red_pkg.sv
// Shared constants and encodings for the sequential modular reducer.
// Moduli are q = 2^255-19 and the ed25519 group order l.
package mod_red_pkg;
  localparam int OUT_W_DEF = 257;

  localparam logic [OUT_W_DEF-1:0] Q = (257'd1 << 255) - 257'd19;
  localparam logic [OUT_W_DEF-1:0] L = (257'd1 << 252) + 257'd27742317777372353535851937790883648493;

  typedef enum logic [1:0] {
    MODE_Q   = 2'd0,
    MODE_L   = 2'd1,
    MODE_RT  = 2'd2,
    MODE_RSV = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RUN,
    FIX,
    DONE
  } state_e;
endpackage

// File: rtl/mod_red_step.sv
// One restoring shift-compare-subtract step: r_next = (2r+bit) mod m, assuming r < m.
// The trial value needs one extra bit because 2r+bit can reach 2m-1.
module mod_red_step #(
  parameter int W = 257
) (
  input  logic [W-1:0] i_r,
  input  logic         i_bit,
  input  logic [W-1:0] i_m,
  output logic [W-1:0] o_r_next
);
  logic [W:0] w_t;
  logic [W:0] w_m_ext;
  logic       w_ge;

  assign w_t     = {i_r, i_bit};
  assign w_m_ext = {1'b0, i_m};
  assign w_ge    = (w_t >= w_m_ext);

  assign o_r_next = w_ge ? W'(w_t - w_m_ext) : W'(w_t);
endmodule

// File: rtl/seq_mod_red.sv
// Bit-serial reducer of a signed IN_W-bit operand modulo q, l or a runtime modulus.
// Handshake: start accepted in IDLE, busy while working, single-cycle done with mod/err.
module seq_mod_red
  import mod_red_pkg::*;
#(
  parameter int IN_W  = 514,
  parameter int OUT_W = 257
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [OUT_W-1:0] m_in,
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] mod,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int CNT_W = $clog2(IN_W);

  state_e           r_state;
  logic [1:0]       r_mode;
  logic [OUT_W-1:0] r_m;
  logic             r_sign;
  logic [IN_W-1:0]  r_mag;
  logic [OUT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;

  logic [OUT_W-1:0] w_m_sel;
  logic [IN_W-1:0]  w_mag;
  logic [OUT_W-1:0] w_rem_next;

  always_comb begin
    w_m_sel = '0;
    case (mode)
      MODE_Q:  w_m_sel = OUT_W'(Q);
      MODE_L:  w_m_sel = OUT_W'(L);
      MODE_RT: w_m_sel = m_in;
      default: w_m_sel = '0;
    endcase
  end

  // Two's-complement negation also maps -2^(IN_W-1) onto its unsigned magnitude.
  assign w_mag = x[IN_W-1] ? (IN_W'(0) - x) : x;

  // Magnitude is shifted out MSB-first instead of indexed by the counter.
  mod_red_step #(
    .W(OUT_W)
  ) u_step (
    .i_r     (r_rem),
    .i_bit   (r_mag[IN_W-1]),
    .i_m     (r_m),
    .o_r_next(w_rem_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mode  <= '0;
      r_m     <= '0;
      r_sign  <= 1'b0;
      r_mag   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      mod     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode  <= mode;
            r_m     <= w_m_sel;
            r_sign  <= x[IN_W-1];
            r_mag   <= w_mag;
            r_rem   <= '0;
            busy    <= 1'b1;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (r_mode == MODE_RSV || r_m == '0) begin
            err     <= 1'b1;
            mod     <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt   <= CNT_W'(IN_W - 1);
            r_state <= RUN;
          end
        end
        RUN: begin
          r_rem <= w_rem_next;
          r_mag <= r_mag << 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= FIX;
        end
        FIX: begin
          // A zero remainder stays zero for negative operands (no m-0 wrap).
          mod     <= (r_sign && r_rem != '0) ? (r_m - r_rem) : r_rem;
          err     <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mod_red.sv
// Randomized self-checking bench for seq_mod_red against a plain-arithmetic residue model.
module tb_seq_mod_red;
  localparam int IN_W      = 514;
  localparam int OUT_W     = 257;
  localparam int LEGAL_LAT = IN_W + 3;
  localparam int ILL_LAT   = 2;

  localparam logic [OUT_W-1:0] QV = (257'd1 << 255) - 257'd19;
  localparam logic [OUT_W-1:0] LV = (257'd1 << 252) + 257'd27742317777372353535851937790883648493;
  localparam logic [OUT_W-1:0] Q_MINUS_10 =
    257'd57896044618658097711785492504343953926634992332820282019728792003956564819939;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       mode  = 2'd0;
  logic [OUT_W-1:0] m_in  = '0;
  logic [IN_W-1:0]  x     = '0;
  logic [OUT_W-1:0] mod;
  logic             busy;
  logic             done;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;

  seq_mod_red #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .mode (mode),
    .m_in (m_in),
    .x    (x),
    .mod  (mod),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [IN_W-1:0] got, input logic [IN_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] rand_x();
    logic [IN_W-1:0] v;
    v = '0;
    for (int i = 0; i < 17; i++) v = {v[IN_W-33:0], 32'($urandom())};
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] rand_m();
    logic [OUT_W-1:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v = {v[OUT_W-33:0], 32'($urandom())};
    return v;
  endfunction

  // Least non-negative residue of a signed operand, straight from modular arithmetic.
  function automatic logic [OUT_W-1:0] gold(input logic [1:0] md, input logic [OUT_W-1:0] mi,
                                            input logic [IN_W-1:0] xv, output logic e);
    logic [OUT_W-1:0] m;
    logic [IN_W-1:0]  mag;
    logic [IN_W-1:0]  rem;
    case (md)
      2'd0:    m = QV;
      2'd1:    m = LV;
      2'd2:    m = mi;
      default: m = '0;
    endcase
    e = (md == 2'd3) || (m == '0);
    if (e) return '0;
    mag = xv[IN_W-1] ? (IN_W'(0) - xv) : xv;
    rem = mag % IN_W'(m);
    if (xv[IN_W-1] && rem != '0) return m - OUT_W'(rem);
    return OUT_W'(rem);
  endfunction

  task automatic run_req(input string tag, input logic [1:0] md, input logic [OUT_W-1:0] mi,
                         input logic [IN_W-1:0] xv, input int poke_at);
    logic [OUT_W-1:0] em;
    logic [OUT_W-1:0] prev_mod;
    logic             ee;
    logic             moved;
    int               n;
    em = gold(md, mi, xv, ee);
    @(negedge clk);
    start = 1'b1; mode = md; m_in = mi; x = xv;
    prev_mod = mod;
    @(negedge clk);
    start = 1'b0; mode = 2'($urandom()); m_in = rand_m(); x = rand_x();
    n = 0;
    moved = 1'b0;
    while (!done && n < IN_W + 20) begin
      if (mod !== prev_mod) moved = 1'b1;
      if (poke_at > 0 && n == poke_at) begin
        start = 1'b1;
        x = rand_x();
      end else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, " latency"}, IN_W'(n + 1), IN_W'(ee ? ILL_LAT : LEGAL_LAT));
    check({tag, " mod"}, IN_W'(mod), IN_W'(em));
    check({tag, " err"}, IN_W'(err), IN_W'(ee));
    check({tag, " busy_at_done"}, IN_W'(busy), '0);
    check({tag, " mod_held_in_run"}, IN_W'(moved), '0);
    // A start presented in the done cycle must not launch a run.
    start = 1'b1; x = rand_x(); mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    check({tag, " done_single"}, IN_W'(done), '0);
    check({tag, " start_in_done_ignored"}, IN_W'(busy), '0);
  endtask

  initial begin
    logic [IN_W-1:0] v;
    logic            seen;
    logic            e_unused;

    repeat (3) @(negedge clk);
    check("reset mod", IN_W'(mod), '0);
    check("reset busy", IN_W'(busy), '0);
    check("reset done", IN_W'(done), '0);
    check("reset err", IN_W'(err), '0);
    rst_n = 1'b1;

    run_req("q_neg10", 2'd0, '0, IN_W'(0) - IN_W'(10), 0);
    check("q_neg10 const", IN_W'(mod), IN_W'(Q_MINUS_10));
    run_req("q_2p255", 2'd0, '0, IN_W'(1) << 255, 0);
    check("q_2p255 const", IN_W'(mod), IN_W'(19));
    run_req("q_q", 2'd0, '0, IN_W'(QV), 0);
    check("q_q const", IN_W'(mod), '0);
    run_req("q_negq", 2'd0, '0, IN_W'(0) - IN_W'(QV), 0);
    check("q_negq const", IN_W'(mod), '0);

    run_req("l_lp5", 2'd1, '0, IN_W'(LV) + IN_W'(5), 0);
    check("l_lp5 const", IN_W'(mod), IN_W'(5));
    run_req("l_neg1", 2'd1, '0, '1, 0);
    check("l_neg1 const", IN_W'(mod), IN_W'(LV - 257'd1));
    run_req("l_min", 2'd1, '0, IN_W'(1) << (IN_W - 1), 0);

    run_req("rt7_neg10", 2'd2, 257'd7, IN_W'(0) - IN_W'(10), 0);
    check("rt7_neg10 const", IN_W'(mod), IN_W'(4));
    run_req("rt0", 2'd2, '0, rand_x(), 0);
    run_req("rsv", 2'd3, rand_m(), rand_x(), 0);
    run_req("q_zero", 2'd0, '0, '0, 0);

    v = rand_x();
    run_req("busy_poke", 2'd1, '0, v, 50);
    check("busy_poke first_operand", IN_W'(mod), IN_W'(gold(2'd1, '0, v, e_unused)));
    run_req("b2b_a", 2'd0, '0, rand_x(), 0);
    run_req("b2b_b", 2'd1, '0, rand_x(), 0);

    // Abort mid-run with reset.
    @(negedge clk);
    start = 1'b1; mode = 2'd0; x = rand_x();
    @(negedge clk);
    start = 1'b0;
    repeat (199) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort mod", IN_W'(mod), '0);
    check("abort busy", IN_W'(busy), '0);
    check("abort done", IN_W'(done), '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (IN_W + 10) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort no_done", IN_W'(seen), '0);
    run_req("after_abort", 2'd0, '0, IN_W'(0) - IN_W'(10), 0);

    for (int i = 0; i < 6; i++) begin
      run_req("rand_q", 2'd0, '0, rand_x(), 0);
      run_req("rand_l", 2'd1, '0, rand_x(), 0);
      run_req("rand_rt_wide", 2'd2, rand_m() | 257'd1, rand_x(), 0);
      run_req("rand_rt_small", 2'd2, OUT_W'($urandom_range(1, 1000)), rand_x(), 0);
    end
    run_req("rand_rsv", 2'd3, rand_m(), rand_x(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_mod_red.md
Name: seq_mod_red

Overview:
Parametrised, multi-modulus successor to the team's sequential 2^255-19 reducer. Takes a signed two's-complement operand up to IN_W bits and returns its least non-negative residue modulo q (2^255-19), l (the ed25519 group order) or a runtime modulus. Uses bit-serial restoring shift-subtract with start/busy/done handshake. Sits after the field/scalar multipliers in the ed25519 datapath.

Parameters:
IN_W, 514, operand width (signed two's complement), >= OUT_W+1
OUT_W, 257, residue/modulus width; every modulus must be < 2^OUT_W

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
mode  input  2  0=q, 1=l, 2=m_in, 3=reserved
m_in  input  OUT_W  runtime modulus, used when mode=2
x  input  IN_W  signed operand, sampled with start
mod  output  OUT_W  residue, 0 <= mod < m
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle pulse, result valid
err  output  1  valid with done; mode=3 or (mode=2 and m_in==0)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mod=0, busy=0, done=0, err=0. Internal registers cleared. Asserting reset mid-run aborts with no done pulse.
- IDLE: on start=1 at posedge T, latch mode, modulus m (q, l or m_in), sign=x[IN_W-1], mag=|x| as IN_W-bit unsigned. The magnitude of -2^(IN_W-1) fits in IN_W bits. Clear remainder r. Go to CHECK.
- CHECK (1 cycle): if the mode is illegal or m==0, go to DONE with err=1 and mod=0. Otherwise go to RUN with counter=IN_W-1.
- RUN (IN_W cycles): each cycle t = 2r + mag[counter]; r = (t >= m) ? t-m : t. r and t are OUT_W+1 bits wide, and the invariant is r < m. Decrement counter; leave RUN after counter 0.
- FIX (1 cycle): if sign=1 and r!=0, mod = m - r; else mod = r. err=0.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: legal request accepted at T gives done at T+IN_W+3 (517 at defaults). Illegal request gives done at T+2.
- mod and err hold their value until the next request completes. mod is not updated during a run.
- busy=1 in CHECK, RUN and FIX.
- start while not in IDLE is ignored, with no queuing. x, mode and m_in may change freely after acceptance.
- start in the DONE cycle is ignored. A new request is accepted only from IDLE, one cycle after done.
- x=0 gives mod=0. x = ±k·m gives mod=0, with no m-0 wrap in FIX.

Decomposition:
- Package mod_red_pkg:
  - constants Q and L, width OUT_W;
  - mode codes MODE_Q, MODE_L, MODE_RT, MODE_RSV;
  - state enum IDLE, CHECK, RUN, FIX, DONE.
- Sub-module mod_red_step: combinational single shift-compare-subtract step.
  - inputs: r, bit, m. Output: r_next.
  - OUT_W+1 internal width; reused by the future radix-2^k variant.

Test Plan:
1. mode=0, x=-10 -> after 517 cycles mod=57896044618658097711785492504343953926634992332820282019728792003956564819939, err=0, a single done pulse.
2. mode=0, x=2^255 -> mod=19. mode=0, x=q -> 0. mode=0, x=-q -> 0, not q.
3. mode=1, x=l+5 -> 5. mode=1, x=-1 -> l-1. mode=1, x=-2^513 -> the matching residue from the golden model.
4. mode=2, m_in=7, x=-10 -> 4. mode=2, m_in=0 -> done at T+2 with err=1, mod=0. mode=3 -> err=1.
5. Second start while busy -> ignored: exactly one done, and the result belongs to the first operand. Back-to-back requests from IDLE both complete.
6. rst_n pulled low at cycle 200 of a run -> mod=0, busy=0, no done. A new request after release completes correctly. Random signed x in all modes is checked against the golden model.
